// File: rtl/rs232_pkg.sv
// Shared types and constants for the RS232 receive path.
package rs232_pkg;

    localparam int BIT_COUNT = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic int baud_count(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/axis_skid_buffer2.sv
// Two-entry FIFO presenting its head as an AXI-stream source.
// A push into a full buffer is accepted only when the head pops in the same cycle.
module axis_skid_buffer2 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    input  logic             ready,
    output logic             pop,
    output logic             full,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry_reg [2];
    logic             rd_ptr_reg;
    logic             wr_ptr_reg;
    logic [1:0]       count_reg;
    logic [1:0]       count_next;
    logic             accept;

    assign valid  = (count_reg != 2'd0);
    assign full   = (count_reg == 2'd2);
    assign count  = count_reg;
    assign pop    = valid && ready;
    assign accept = push && (!full || pop);
    assign rdata  = entry_reg[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (accept && !pop) begin
            count_next = count_reg + 2'd1;
        end else if (pop && !accept) begin
            count_next = count_reg - 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            entry_reg[0] <= '0;
            entry_reg[1] <= '0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
        end else begin
            if (accept) begin
                entry_reg[wr_ptr_reg] <= wdata;
                wr_ptr_reg            <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/rs232_to_axis.sv
// RS232 receiver with RTS flow control, delivering bytes as an AXI-stream source.
// Define RS232RX_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module rs232_to_axis
    import rs232_pkg::*;
#(
    parameter int CLOCK_FREQ = 133000000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clock,
    input  logic       resetn,
    output logic [7:0] odata,
    output logic       ovalid,
    input  logic       oready,
    input  logic       rxd,
    output logic       rtsn,
    output logic       ferror,
    output logic       overrun
);

    localparam int BAUD_COUNT = baud_count(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W      = $clog2(BAUD_COUNT);
    localparam int IDX_W      = $clog2(BIT_COUNT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_COUNT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_COUNT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BIT_COUNT - 1);

    logic [1:0]       sync_reg;
    logic             rxs;
    logic [CNT_W-1:0] cnt_reg;
    logic             tc;
    logic             sample;
    logic             bit_val;

    rx_state_t        state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             push;
    logic             ferror_next;
    logic             ferror_reg;
    logic             overrun_reg;
    logic             rtsn_reg;

    logic             buf_pop;
    logic             buf_full;
    logic [1:0]       buf_count;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rxd};
        end
    end

    assign rxs = sync_reg[1];

    // The counter only means anything while a frame is in progress.
    assign tc = (cnt_reg == '0) &&
                (state_reg == START || state_reg == DATA || state_reg == STOP);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_reg <= '0;
        end else if (state_reg == IDLE && !rxs) begin
            cnt_reg <= HALF_LOAD;
        end else if (tc) begin
            cnt_reg <= FULL_LOAD;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

`ifdef RS232RX_MAJORITY_EN
    logic [1:0] hist_reg;
    logic       tc_d_reg;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            hist_reg <= 2'b11;
            tc_d_reg <= 1'b0;
        end else begin
            hist_reg <= {hist_reg[0], rxs};
            tc_d_reg <= tc;
        end
    end

    // One cycle after the sample point the window -1/0/+1 is fully visible.
    assign sample  = tc_d_reg;
    assign bit_val = (rxs & hist_reg[0]) | (rxs & hist_reg[1]) | (hist_reg[0] & hist_reg[1]);
`else
    assign sample  = tc;
    assign bit_val = rxs;
`endif

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        shift_next  = shift_reg;
        push        = 1'b0;
        ferror_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rxs) begin
                    state_next = START;
                end
            end
            START: begin
                if (sample) begin
                    if (!bit_val) begin
                        state_next = DATA;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_next = {bit_val, shift_reg[7:1]};
                    if (idx_reg == LAST_IDX) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (sample) begin
                    if (bit_val) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferror_next = 1'b1;
                        state_next  = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            shift_reg   <= '0;
            ferror_reg  <= 1'b0;
            overrun_reg <= 1'b0;
            rtsn_reg    <= 1'b1;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            shift_reg   <= shift_next;
            ferror_reg  <= ferror_next;
            overrun_reg <= push && buf_full && !buf_pop;
            // Buffer is non-empty next cycle on any push (a dropped push implies full).
            rtsn_reg    <= push || buf_full || (buf_count == 2'd1 && !buf_pop);
        end
    end

    axis_skid_buffer2 #(
        .WIDTH (8)
    ) u_buffer (
        .clock  (clock),
        .resetn (resetn),
        .push   (push),
        .wdata  (shift_next),
        .rdata  (odata),
        .valid  (ovalid),
        .ready  (oready),
        .pop    (buf_pop),
        .full   (buf_full),
        .count  (buf_count)
    );

    assign rtsn    = rtsn_reg;
    assign ferror  = ferror_reg;
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_rs232_to_axis.sv
// Scoreboard bench for rs232_to_axis at 10 clocks per bit.
module tb_rs232_to_axis;

`ifdef RS232RX_MAJORITY_EN
    localparam int LAT = 99;
    localparam logic [7:0] GLITCH_BYTE = 8'hFF;
`else
    localparam int LAT = 98;
    localparam logic [7:0] GLITCH_BYTE = 8'hF7;
`endif

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       oready = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] odata;
    logic       ovalid;
    logic       rtsn;
    logic       ferror;
    logic       overrun;

    rs232_to_axis #(
        .CLOCK_FREQ (1000000),
        .BAUD_RATE  (100000)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .odata   (odata),
        .ovalid  (ovalid),
        .oready  (oready),
        .rxd     (rxd),
        .rtsn    (rtsn),
        .ferror  (ferror),
        .overrun (overrun)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int pops = 0, valid_cycles = 0, ferrors = 0, overruns = 0;
    int rise_cyc = -1, ferror_cyc = -1, fall_cyc = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and tallies pulses.
    always @(negedge clock) begin
        if (!resetn) begin
            prev_valid = 1'b0;
        end else begin
            if (ovalid) valid_cycles++;
            if (ovalid && !prev_valid) rise_cyc = cyc;
            prev_valid = ovalid;
            if (ferror) begin
                ferrors++;
                ferror_cyc = cyc;
            end
            if (overrun) overruns++;
            if (ovalid && oready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%02h required=none", odata);
                end else begin
                    $display("byte %02h expected %02h at cycle %0d", odata, exp_q[0], cyc);
                    check("odata", odata, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drives one 10-bit frame; glitch_k inverts a single clock, abort_k stops early.
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input int glitch_k, input int abort_k);
        logic [9:0] frame;
        frame = {stop, data, 1'b0};
        for (int k = 0; k < 100; k++) begin
            if (k == abort_k) return;
            if (k == 0) fall_cyc = cyc;
            rxd = (k == glitch_k) ? ~frame[k / 10] : frame[k / 10];
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_reset_values();
        check("rst_ovalid", ovalid, 0);
        check("rst_odata", odata, 0);
        check("rst_rtsn", rtsn, 1);
        check("rst_ferror", ferror, 0);
        check("rst_overrun", overrun, 0);
    endtask

    int v0, f0, o0, p0;

    initial begin
        tick(2);
        check_reset_values();
        resetn = 1'b1;
        tick(1);
        check("rtsn_after_release", rtsn, 0);
        tick(5);

        // Single byte, free-flowing sink
        oready = 1'b1;
        v0 = valid_cycles;
        f0 = ferrors;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, -1, -1);
        check("t1_latency", rise_cyc - fall_cyc, LAT);
        tick(5);
        check("t1_valid_cycles", valid_cycles - v0, 1);
        check("t1_ferror", ferrors - f0, 0);

        // Two bytes held by a stalled sink, then drained
        oready = 1'b0;
        check("t2_rtsn_idle", rtsn, 0);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        send_frame(8'hA5, 1'b1, -1, -1);
        check("t2_rtsn_after_push", rtsn, 1);
        send_frame(8'h3C, 1'b1, -1, -1);
        tick(5);
        check("t2_held_valid", ovalid, 1);
        check("t2_held_head", odata, 8'hA5);
        p0 = pops;
        oready = 1'b1;
        tick(2);
        check("t2_consecutive_pops", pops - p0, 2);
        check("t2_empty", ovalid, 0);
        check("t2_rtsn_drained", rtsn, 0);

        // Third byte into a full buffer is dropped
        oready = 1'b0;
        o0 = overruns;
        p0 = pops;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        send_frame(8'hA5, 1'b1, -1, -1);
        send_frame(8'h3C, 1'b1, -1, -1);
        send_frame(8'h99, 1'b1, -1, -1);
        tick(5);
        check("t3_overrun", overruns - o0, 1);
        oready = 1'b1;
        tick(5);
        check("t3_pops", pops - p0, 2);
        check("t3_empty", ovalid, 0);

        // Framing error on a zero stop bit
        f0 = ferrors;
        v0 = valid_cycles;
        send_frame(8'h81, 1'b0, -1, -1);
        rxd = 1'b1;
        tick(10);
        check("t4_ferror", ferrors - f0, 1);
        check("t4_ferror_time", ferror_cyc - fall_cyc, LAT);
        check("t4_no_valid", valid_cycles - v0, 0);

        // Line held low for 30 bit times, then a clean byte
        f0 = ferrors;
        v0 = valid_cycles;
        rxd = 1'b0;
        tick(300);
        rxd = 1'b1;
        tick(30);
        check("t5_one_ferror", ferrors - f0, 1);
        check("t5_no_valid", valid_cycles - v0, 0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, -1, -1);
        tick(5);

        // Short start glitch is rejected
        f0 = ferrors;
        v0 = valid_cycles;
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(150);
        check("t6_no_ferror", ferrors - f0, 0);
        check("t6_no_valid", valid_cycles - v0, 0);

        // One-clock glitch landing on the bit-3 sample point
        exp_q.push_back(GLITCH_BYTE);
        send_frame(8'hFF, 1'b1, 45, -1);
        tick(5);
        check("t7_latency", rise_cyc - fall_cyc, LAT);

        // Reset in the middle of bit 4
        send_frame(8'h5A, 1'b1, -1, 55);
        resetn = 1'b0;
        rxd = 1'b1;
        tick(2);
        check_reset_values();
        resetn = 1'b1;
        tick(1);
        check("t8_rtsn_release", rtsn, 0);
        tick(20);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, -1, -1);
        tick(5);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
